// File: rtl/led_display_scan_pkg.sv
// Shared constants for the multiplexed hex LED display: segment width, off pattern and glyph table.
// Segment vectors are indexed [0:6] = a..g and are active-low (0 = lit).
package led_display_pkg;

    localparam int SEG_W = 7;
    localparam logic [0:SEG_W-1] SEG_OFF = 7'b1111111;

    localparam logic [0:SEG_W-1] GLYPH_TABLE [16] = '{
        7'b0000001, // 0
        7'b1001111, // 1
        7'b0010010, // 2
        7'b0000110, // 3
        7'b1001100, // 4
        7'b0100100, // 5
        7'b0100000, // 6
        7'b0001111, // 7
        7'b0000000, // 8
        7'b0000100, // 9
        7'b0001000, // A
        7'b1100000, // b
        7'b0110001, // C
        7'b1000010, // d
        7'b0110000, // E
        7'b0111000  // F
    };

endpackage

// File: rtl/led_display_scan_if.sv
// Load/digit/blink inputs and seg/an/pending outputs of the display scanner.
// master = the block driving digit data, slave = the scanner itself.
interface led_display_scan_if
    import led_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic [NUM_DIGITS-1:0]   blink_in;
    logic [0:SEG_W-1]        seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    pending;

    modport master (
        output load, digits_in, blank_in, blink_in,
        input  seg, an, pending
    );

    modport slave (
        input  load, digits_in, blank_in, blink_in,
        output seg, an, pending
    );
endinterface

// File: rtl/led_seg_decode.sv
// Hex nibble to active-low 7-segment glyph (a..g on bits [0:6]).
// Latency: purely combinational. Backpressure: none.
module led_seg_decode
    import led_display_pkg::*;
(
    input  logic [3:0]       nib_i,
    output logic [0:SEG_W-1] seg_o
);
    always_comb begin
        seg_o = GLYPH_TABLE[nib_i];
    end
endmodule

// File: rtl/led_display_scan.sv
// Time-multiplexed hex LED scanner with double-buffered digits committed on frame boundaries.
// Latency: seg/an registered, updated together; loads shown from the next frame. Backpressure: none, loads overwrite.
// Optional blink (macro LED_DISPLAY_BLINK_EN) blanks blink_in digits on alternate BLINK_DIV-frame periods.
module led_display_scan
    import led_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 256
)(
    input  logic               clk,
    input  logic               rst_n,
    led_display_scan_if.slave  bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int DIG_W = 4 * NUM_DIGITS;

    logic [PRE_W-1:0]      pre_q,       pre_d;
    logic [IDX_W-1:0]      idx_q,       idx_d;
    logic [DIG_W-1:0]      act_dig_q,   act_dig_d;
    logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;
    logic [DIG_W-1:0]      shd_dig_q,   shd_dig_d;
    logic [NUM_DIGITS-1:0] shd_blank_q, shd_blank_d;
    logic                  pending_q,   pending_d;
    logic [0:SEG_W-1]      seg_q,       seg_d;
    logic [NUM_DIGITS-1:0] an_q,        an_d;

    logic                  term;
    logic                  wrap;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic [0:SEG_W-1]      dec_seg;

    always_comb begin
        term = (pre_q == PRE_W'(SCAN_DIV - 1));
        wrap = term && (idx_q == IDX_W'(NUM_DIGITS - 1));

        pre_d = term ? '0 : pre_q + 1'b1;
        if (wrap) begin
            idx_d = '0;
        end else if (term) begin
            idx_d = idx_q + 1'b1;
        end else begin
            idx_d = idx_q;
        end

        // Commit uses the shadow as it stood before this edge, so a coincident load waits a frame.
        act_dig_d   = (wrap && pending_q) ? shd_dig_q   : act_dig_q;
        act_blank_d = (wrap && pending_q) ? shd_blank_q : act_blank_q;
        shd_dig_d   = bus.load ? bus.digits_in : shd_dig_q;
        shd_blank_d = bus.load ? bus.blank_in  : shd_blank_q;
        pending_d   = bus.load | (pending_q & ~wrap);
    end

`ifdef LED_DISPLAY_BLINK_EN
    localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [FRM_W-1:0] frm_q, frm_d;
    logic             phase_q, phase_d;

    always_comb begin
        frm_d   = frm_q;
        phase_d = phase_q;
        if (wrap) begin
            if (frm_q == FRM_W'(BLINK_DIV - 1)) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
        end
        blink_mask = phase_d ? bus.blink_in : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            frm_q   <= frm_d;
            phase_q <= phase_d;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^bus.blink_in;

    always_comb begin
        blink_mask = '0;
    end
`endif

    // Decode from next-state values so seg and an move on the same edge.
    always_comb begin
        cur_nib   = act_dig_d[{idx_d, 2'b00} +: 4];
        cur_blank = act_blank_d[idx_d] | blink_mask[idx_d];
        seg_d     = cur_blank ? SEG_OFF : dec_seg;
        an_d      = ~(NUM_DIGITS'(1) << idx_d);
    end

    led_seg_decode u_seg_decode (
        .nib_i (cur_nib),
        .seg_o (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q       <= '0;
            idx_q       <= '0;
            act_dig_q   <= '0;
            act_blank_q <= '1;
            shd_dig_q   <= '0;
            shd_blank_q <= '1;
            pending_q   <= 1'b0;
            seg_q       <= SEG_OFF;
            an_q        <= '1;
        end else begin
            pre_q       <= pre_d;
            idx_q       <= idx_d;
            act_dig_q   <= act_dig_d;
            act_blank_q <= act_blank_d;
            shd_dig_q   <= shd_dig_d;
            shd_blank_q <= shd_blank_d;
            pending_q   <= pending_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.an      = an_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_led_display_scan.sv
// Directed + randomized bench for led_display_scan against an edge-count reference model.
module tb_led_display_scan;
    import led_display_pkg::*;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BD = 2;
    localparam int FRAME = SD * N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    led_display_scan_if #(.NUM_DIGITS(N)) bus ();

    led_display_scan #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: edges since reset release plus the double buffer contents.
    int               k;
    logic [4*N-1:0]   m_shd_dig, m_act_dig;
    logic [N-1:0]     m_shd_blk, m_act_blk;
    logic             m_pend;
    logic [N-1:0]     m_blink;
    logic [3:0]       blink_drv;
    bit               blink_rnd;
    string            tag;
    int               seen_one;

    function automatic logic [0:6] ref_glyph(input logic [3:0] v);
        string lit;
        logic [0:6] s;
        case (v)
            4'h0: lit = "abcdef";  4'h1: lit = "bc";
            4'h2: lit = "abdeg";   4'h3: lit = "abcdg";
            4'h4: lit = "bcfg";    4'h5: lit = "acdfg";
            4'h6: lit = "acdefg";  4'h7: lit = "abc";
            4'h8: lit = "abcdefg"; 4'h9: lit = "abcdfg";
            4'hA: lit = "abcefg";  4'hB: lit = "cdefg";
            4'hC: lit = "adef";    4'hD: lit = "bcdeg";
            4'hE: lit = "adefg";   default: lit = "aefg";
        endcase
        s = 7'b1111111;
        for (int i = 0; i < lit.len(); i++) s[int'(lit[i]) - 97] = 1'b0;
        return s;
    endfunction

    task automatic check(input string name, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", name, obs, exp, k);
        end
    endtask

    task automatic model_reset();
        k         = 0;
        m_shd_dig = '0;
        m_act_dig = '0;
        m_shd_blk = '1;
        m_act_blk = '1;
        m_pend    = 1'b0;
        m_blink   = '0;
    endtask

    task automatic check_outputs();
        int         idx;
        int         phase;
        logic [0:6] exp_seg;
        logic [N-1:0] exp_an;
        if (k == 0) begin
            exp_seg = 7'b1111111;
            exp_an  = '1;
        end else begin
            idx   = (k / SD) % N;
            phase = 0;
`ifdef LED_DISPLAY_BLINK_EN
            phase = ((k / FRAME) / BD) % 2;
`endif
            exp_an = '1;
            exp_an[idx] = 1'b0;
            if (m_act_blk[idx] || (phase == 1 && m_blink[idx]))
                exp_seg = 7'b1111111;
            else
                exp_seg = ref_glyph(m_act_dig[4*idx +: 4]);
        end
        check({tag, ".seg"},     16'(bus.seg),     16'(exp_seg));
        check({tag, ".an"},      16'(bus.an),      16'(exp_an));
        check({tag, ".pending"}, 16'(bus.pending), 16'(m_pend));
    endtask

    task automatic step(input logic ld, input logic [15:0] dig, input logic [3:0] blk, input logic [3:0] bl);
        bit boundary;
        bus.load      = ld;
        bus.digits_in = dig;
        bus.blank_in  = blk;
        bus.blink_in  = bl;
        @(posedge clk);
        k++;
        boundary = (k % FRAME) == 0;
        if (boundary && m_pend) begin
            m_act_dig = m_shd_dig;
            m_act_blk = m_shd_blk;
        end
        m_pend = ld | (m_pend & !boundary);
        if (ld) begin
            m_shd_dig = dig;
            m_shd_blk = blk;
        end
        m_blink = bl;
        #1;
        check_outputs();
        if (bus.seg === ref_glyph(4'h1)) seen_one++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 16'($urandom), 4'($urandom), blink_rnd ? 4'($urandom) : blink_drv);
    endtask

    // Advance until the edge count modulo one frame reaches r (bounded).
    task automatic advance_to(input int r);
        for (int i = 0; i < 2 * FRAME && (k % FRAME) != r; i++) idle(1);
        check({tag, ".advance"}, 16'(k % FRAME), 16'(r));
    endtask

    initial begin
        bus.load = 1'b0; bus.digits_in = '0; bus.blank_in = '0; bus.blink_in = '0;
        blink_drv = '0; blink_rnd = 1'b1; seen_one = 0;
        model_reset();

        tag = "reset";
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        check_outputs();

        tag = "idle_scan";
        idle(2 * FRAME);

        tag = "load_mid";
        blink_rnd = 1'b0;
        advance_to(6);
        step(1'b1, 16'h3A07, 4'h0, 4'h0);
        check("load_mid.pending_set", 16'(bus.pending), 16'd1);
        advance_to(1);
        check("load_mid.digit0_7", 16'(bus.seg), 16'(7'b0001111));
        check("load_mid.pending_clr", 16'(bus.pending), 16'd0);
        advance_to(13);
        check("load_mid.digit3_3", 16'(bus.seg), 16'(7'b0000110));

        tag = "two_loads";
        advance_to(2);
        seen_one = 0;
        step(1'b1, 16'h1111, 4'h0, 4'h0);
        idle(4);
        step(1'b1, 16'h2222, 4'h0, 4'h0);
        idle(2 * FRAME);
        check("two_loads.no_1111", 16'(seen_one), 16'd0);

        tag = "coincident";
        advance_to(5);
        step(1'b1, 16'h4567, 4'h0, 4'h0);
        advance_to(FRAME - 1);
        step(1'b1, 16'h89AB, 4'h2, 4'h0);
        check("coincident.pending_kept", 16'(bus.pending), 16'd1);
        idle(2 * FRAME);

        tag = "random";
        blink_rnd = 1'b1;
        for (int i = 0; i < 96; i++)
            step(($urandom_range(0, 3) == 0), 16'($urandom), 4'($urandom), 4'($urandom));

        tag = "reset_mid";
        advance_to(3);
        step(1'b1, 16'h5F5F, 4'h0, 4'h0);
        idle(5);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        idle(2 * FRAME);

        tag = "blink";
        blink_rnd = 1'b0;
        blink_drv = 4'b0001;
        step(1'b1, 16'h0123, 4'h0, blink_drv);
        idle(10 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/led_display_scan.md
LED_DISPLAY_SCAN -- requirements
Module: led_display_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4; number of multiplexed digits, legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 1000; clock cycles each digit stays enabled, legal range 2..65535.
REQ-003 Parameter BLINK_DIV, default 256; number of scan frames per blink half-period, legal range 1..1023.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 load  input  1  request to capture digits_in and blank_in.
REQ-007 digits_in  input  4*NUM_DIGITS  hex nibble per digit; digit i occupies bits [4i+3:4i].
REQ-008 blank_in  input  NUM_DIGITS  per-digit blank flag; 1 forces the digit off.
REQ-009 blink_in  input  NUM_DIGITS  per-digit blink enable; sampled live, not via load.
REQ-010 seg  output  7  segments a..g as bits [0:6], active-low (0 lit).
REQ-011 an  output  NUM_DIGITS  digit enables, active-low, one-hot-cold.
REQ-012 pending  output  1  high while a captured load waits for the frame boundary.

Function
REQ-013 Glyphs SHALL be standard hex 0-F; lit segments: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=all, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg.
REQ-014 A prescaler SHALL count 0..SCAN_DIV-1; on the terminal count the digit index advances by 1.
REQ-015 Digit index SHALL wrap from NUM_DIGITS-1 to 0; that wrap is the frame boundary.
REQ-016 an SHALL drive low only bit [index]; seg SHALL be registered so that seg and an change on the same edge.
REQ-017 load=1 SHALL capture digits_in/blank_in into a shadow register on that edge and SHALL set pending on the next cycle.
REQ-018 At the frame boundary with pending=1, the shadow SHALL copy into the active register and pending SHALL clear on the same edge.
REQ-019 A load on the same edge as the frame boundary SHALL be captured into the shadow and SHALL leave pending=1; the prior shadow commits on that edge.
REQ-020 Repeated loads before the boundary SHALL overwrite the shadow; only the last load commits.
REQ-021 A blanked digit SHALL output seg=7'b1111111 while its an bit is still asserted.
REQ-022 NUM_DIGITS=1 SHALL produce a frame boundary on every prescaler terminal count.

Reset
REQ-023 While rst_n=0: prescaler=0, index=0, active and shadow digits=0, blank=all 1, pending=0, blink phase=0, seg=7'b1111111, an=all 1.
REQ-024 After release, the first an assertion (bit 0) SHALL occur on the first rising edge.
REQ-025 A reset asserted mid-frame SHALL discard pending shadow contents.

Configuration
REQ-026 Macro LED_DISPLAY_BLINK_EN defined: a frame counter toggles blink phase every BLINK_DIV frames; digits with blink_in=1 are blanked while phase=1.
REQ-027 Macro LED_DISPLAY_BLINK_EN undefined: no blink counter is built; blink_in is ignored; behaviour is otherwise identical.

Structure
REQ-028 Package led_display_pkg SHALL hold the 16-entry glyph constant table, SEG_W=7, and SEG_OFF=7'b1111111.
REQ-029 A combinational sub-module led_seg_decode (4-bit in, 7-bit active-low out) SHALL implement the glyph table; this block instantiates one copy.

Verification
REQ-030 Reset release, NUM_DIGITS=4, SCAN_DIV=4, no load -> an cycles 1110,1101,1011,0111 every 4 clocks; seg=1111111 throughout.
REQ-031 load with digits_in=16'h3A07, blank_in=0 mid-frame -> pending=1 until the wrap to index 0; then digit0 seg=0001111 ('7'), digit3 seg=0000110 ('3').
REQ-032 Two loads (16'h1111, then 16'h2222) in one frame -> only 2222 displayed; 1111 never appears on seg.
REQ-033 load coincident with the frame boundary -> previous shadow commits, pending stays 1, new value commits at the next boundary.
REQ-034 With LED_DISPLAY_BLINK_EN and BLINK_DIV=2, blink_in=4'b0001 -> digit0 alternates glyph and 1111111 every 2 frames; other digits are steady.
REQ-035 rst_n pulsed low mid-frame with pending=1 -> all outputs return to their reset values; the shadow never commits.
